display_scheduler: RTL and testbench

//  Time-shares the 4-digit show16withdps display between NREQ producers.

---
 rtl/display_scheduler.sv | 177 +++++++++++++++++
 tb/tb_display_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin time-sharing of the 4-digit display
// between four producers, with hold time and NEWNUM spacing control.
module display_scheduler #(
    parameter int NREQ   = 4,
    parameter int HOLD   = 2500000,
    parameter int MINGAP = 128
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ,
    input  logic [16*NREQ-1:0] VALS,
    input  logic [4*NREQ-1:0]  DPS,
    output logic [15:0]        NUM,
    output logic [3:0]         DP_OUT,
    output logic               NEWNUM,
    output logic [1:0]         CUR,
    output logic               SHOWING
);

    localparam int HW = $clog2(HOLD + 1);
    localparam int GW = $clog2(MINGAP + 1);

    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(MINGAP);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_pend;
    logic [1:0]      r_rr;
    logic [HW-1:0]   r_hold;
    logic [GW-1:0]   r_gap;
    logic [15:0]     r_val [NREQ];
    logic [3:0]      r_dps [NREQ];
    logic [15:0]     r_num;
    logic [3:0]      r_dp;
    logic            r_newnum;
    logic [1:0]      r_cur;
    logic            r_showing;

    logic            w_gap_ok;
    logic            w_hold_ok;
    logic            w_rr_found;
    logic [1:0]      w_rr_sel;
    logic            w_sw_found;
    logic [1:0]      w_sw_sel;
    logic            w_go;
    logic [1:0]      w_sel;
    logic            w_new_cur;
    logic [NREQ-1:0] w_clr;

    // Both counters read 1 in the pulse cycle itself, so a count of N
    // in a decision cycle places the next pulse exactly N cycles later.
    assign w_gap_ok  = (r_gap == GAP_MAX);
    assign w_hold_ok = (r_hold == HOLD_MAX);

    // First pending producer at or after the round-robin pointer.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_sel   = r_rr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (r_pend[r_rr + 2'(k)]) begin
                w_rr_found = 1'b1;
                w_rr_sel   = r_rr + 2'(k);
            end
        end
    end

    // First pending producer after the one on screen, skipping it.
    always_comb begin
        w_sw_found = 1'b0;
        w_sw_sel   = r_cur;
        for (int k = NREQ - 1; k >= 1; k--) begin
            if (r_pend[r_cur + 2'(k)]) begin
                w_sw_found = 1'b1;
                w_sw_sel   = r_cur + 2'(k);
            end
        end
    end

    // Issue decision; a switch to another channel beats a refresh.
    always_comb begin
        w_go  = 1'b0;
        w_sel = r_rr;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_found && w_gap_ok) begin
                    w_go  = 1'b1;
                    w_sel = w_rr_sel;
                end
            end
            ST_SHOW: begin
                if (w_hold_ok && w_gap_ok && w_sw_found) begin
                    w_go  = 1'b1;
                    w_sel = w_sw_sel;
                end else if (r_pend[r_cur] && w_gap_ok) begin
                    w_go  = 1'b1;
                    w_sel = r_cur;
                end
            end
            default: begin
                w_go  = 1'b0;
                w_sel = r_rr;
            end
        endcase
    end

    assign w_new_cur = (r_state == ST_IDLE) || (w_sel != r_cur);
    assign w_clr     = w_go ? (NREQ'(1) << w_sel) : '0;

    // Capture the latest post of each producer; later posts overwrite.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (REQ[i]) begin
                r_val[i] <= VALS[16*i +: 16];
                r_dps[i] <= DPS[4*i +: 4];
            end
        end
    end

    // Scheduler state, pending flags, spacing counter and display outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_pend    <= '0;
            r_rr      <= 2'd0;
            r_gap     <= GAP_MAX;
            r_num     <= 16'd0;
            r_dp      <= 4'd0;
            r_newnum  <= 1'b0;
            r_cur     <= 2'd0;
            r_showing <= 1'b0;
        end else begin
            // A new post in the issue cycle keeps the flag set.
            r_pend   <= (r_pend & ~w_clr) | REQ;
            r_newnum <= w_go;
            if (w_go) begin
                r_state   <= ST_ISSUE;
                r_num     <= r_val[w_sel];
                r_dp      <= r_dps[w_sel];
                r_cur     <= w_sel;
                r_rr      <= w_sel + 2'd1;
                r_showing <= 1'b1;
                r_gap     <= GAP_ONE;
            end else begin
                if (r_state == ST_ISSUE) begin
                    r_state <= ST_SHOW;
                end
                if (!w_gap_ok) begin
                    r_gap <= r_gap + GAP_ONE;
                end
            end
        end
    end

    // Hold timer restarts only when a different channel goes on screen.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold <= '0;
        end else if (w_go && w_new_cur) begin
            r_hold <= HOLD_ONE;
        end else if (!w_hold_ok) begin
            r_hold <= r_hold + HOLD_ONE;
        end
    end

    assign NUM     = r_num;
    assign DP_OUT  = r_dp;
    assign NEWNUM  = r_newnum & ~RST;
    assign CUR     = r_cur;
    assign SHOWING = r_showing;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed stimulus with a pulse scoreboard
// and a continuous NEWNUM spacing / NUM stability monitor.
module tb_display_scheduler;

    localparam int HOLD   = 16;
    localparam int MINGAP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] vals;
    logic [15:0] dps;
    logic [15:0] num;
    logic [3:0]  dp_out;
    logic        newnum;
    logic [1:0]  cur;
    logic        showing;

    display_scheduler #(
        .NREQ   (4),
        .HOLD   (HOLD),
        .MINGAP (MINGAP)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req),
        .VALS    (vals),
        .DPS     (dps),
        .NUM     (num),
        .DP_OUT  (dp_out),
        .NEWNUM  (newnum),
        .CUR     (cur),
        .SHOWING (showing)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_at_edge = 1'b1;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    typedef struct {
        logic [15:0] num;
        logic [3:0]  dp;
        logic [1:0]  cur;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pops on every pulse, plus whole-run invariants.
    exp_t        e;
    int          last_pulse = -1000;
    logic        prev_nn = 1'b0;
    logic [15:0] prev_num = 16'd0;
    logic [3:0]  prev_dp = 4'd0;

    always @(negedge clk) begin
        if (rst || rst_at_edge) begin
            last_pulse = -1000;
        end
        if (newnum) begin
            chk("newnum_width", {31'd0, prev_nn}, 32'd0);
            chk("newnum_gap_ok", {31'd0, (cyc - last_pulse) >= MINGAP}, 32'd1);
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_newnum: pulse at cycle %0d, none expected",
                         cyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_num", {16'd0, num}, {16'd0, e.num});
                chk("pulse_dp", {28'd0, dp_out}, {28'd0, e.dp});
                chk("pulse_cur", {30'd0, cur}, {30'd0, e.cur});
                chk("pulse_showing", {31'd0, showing}, 32'd1);
            end
            last_pulse = cyc;
        end else if (!rst && !rst_at_edge) begin
            if (num !== prev_num || dp_out !== prev_dp) begin
                n_checks++;
                n_errors++;
                $display("FAIL num_stable: NUM %0d DP %0d changed from %0d/%0d without NEWNUM at cycle %0d",
                         num, dp_out, prev_num, prev_dp, cyc);
            end
        end
        prev_nn  = newnum;
        prev_num = num;
        prev_dp  = dp_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        if (cyc > c) begin
            n_checks++;
            n_errors++;
            $display("FAIL schedule: at cycle %0d, wanted %0d", cyc, c);
        end
        while (cyc < c) tick();
    endtask

    task automatic post(input int ch, input logic [15:0] v,
                        input logic [3:0] d);
        req[ch]          = 1'b1;
        vals[16*ch +: 16] = v;
        dps[4*ch +: 4]    = d;
    endtask

    task automatic end_post();
        tick();
        req = 4'd0;
    endtask

    task automatic expect_pulse(input logic [15:0] v, input logic [3:0] d,
                                input logic [1:0] c, input int at);
        exp_t x;
        x.num = v;
        x.dp  = d;
        x.cur = c;
        x.at  = at;
        sb.push_back(x);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_num"}, {16'd0, num}, 32'd0);
        chk({tag, "_dp"}, {28'd0, dp_out}, 32'd0);
        chk({tag, "_newnum"}, {31'd0, newnum}, 32'd0);
        chk({tag, "_cur"}, {30'd0, cur}, 32'd0);
        chk({tag, "_showing"}, {31'd0, showing}, 32'd0);
    endtask

    int c0, t1, t2, t3, t4, t5, t6;

    initial begin
        rst  = 1'b1;
        req  = 4'd0;
        vals = 64'd0;
        dps  = 16'd0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // Single post: pulse two cycles after the request.
        c0 = cyc;
        t1 = c0 + 2;
        post(2, 16'd1234, 4'b0101);
        expect_pulse(16'd1234, 4'b0101, 2'd2, t1);
        end_post();

        // Two posts wait out the hold; 3 first, then wrap to 0.
        go_to(t1 + 3);
        post(0, 16'd1000, 4'b0001);
        post(3, 16'd3333, 4'b1000);
        expect_pulse(16'd3333, 4'b1000, 2'd3, t1 + 16);
        expect_pulse(16'd1000, 4'b0001, 2'd0, t1 + 32);
        end_post();
        t2 = t1 + 32;

        // Bring channel 1 up, refresh it, then switch on the old hold.
        go_to(t2 + 1);
        post(1, 16'd11, 4'b0010);
        expect_pulse(16'd11, 4'b0010, 2'd1, t2 + 16);
        end_post();
        t3 = t2 + 16;
        go_to(t3 + 2);
        post(1, 16'd42, 4'b0011);
        expect_pulse(16'd42, 4'b0011, 2'd1, t3 + 4);
        end_post();
        go_to(t3 + 6);
        post(2, 16'd200, 4'b0100);
        expect_pulse(16'd200, 4'b0100, 2'd2, t3 + 16);
        end_post();
        t4 = t3 + 16;

        // Re-post before service: only the latest value is shown.
        go_to(t4 + 2);
        post(1, 16'd7, 4'b1111);
        end_post();
        go_to(t4 + 5);
        post(1, 16'd9, 4'b1001);
        expect_pulse(16'd9, 4'b1001, 2'd1, t4 + 16);
        end_post();
        t5 = t4 + 16;

        // Switch beats refresh; the refresh request survives.
        go_to(t5 + 2);
        post(3, 16'd300, 4'b0110);
        expect_pulse(16'd300, 4'b0110, 2'd3, t5 + 16);
        expect_pulse(16'd77, 4'b0111, 2'd1, t5 + 32);
        end_post();
        go_to(t5 + 14);
        post(1, 16'd77, 4'b0111);
        end_post();
        t6 = t5 + 32;

        // Reset during the issue cycle suppresses the pulse and work.
        go_to(t6 + 2);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        post(2, 16'd555, 4'b1100);
        end_post();
        post(0, 16'd66, 4'b0011);
        tick();
        req = 4'd0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_issue_newnum", {31'd0, newnum}, 32'd0);
        tick();
        rst = 1'b0;
        chk_zero("rst_issue");
        repeat (40) tick();

        // Normal service after the aborted issue.
        c0 = cyc;
        post(3, 16'hBEEF, 4'b1010);
        expect_pulse(16'hBEEF, 4'b1010, 2'd3, c0 + 2);
        end_post();

        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missing_pulse: NUM %0d CUR %0d never seen (due cycle %0d)",
                     e.num, e.cur, e.at);
        end
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
